// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types for the two-lane sort dispatcher
package sort_pkg;
    localparam int NUM_LANES = 2;

    typedef logic lane_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        CLOSE
    } in_state_t;
endpackage

// File: rtl/sort_lane_merge.sv
// rtl/sort_lane_merge.sv - merges lane outputs in frame order, flags out-of-turn lanes
module sort_lane_merge
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_src_data,
    input  logic [NUM_LANES-1:0]            lane_src_valid,
    input  logic [NUM_LANES-1:0]            lane_src_sop,
    input  logic [NUM_LANES-1:0]            lane_src_eop,
    input  logic [NUM_LANES-1:0]            lane_busy,
    output logic [DATA_WIDTH-1:0]           src_data,
    output logic                            src_valid,
    output logic                            src_sop,
    output logic                            src_eop,
    output logic                            order_err,
    output logic [NUM_LANES-1:0]            busy_clr
);
    lane_idx_t               r_out_sel;
    logic [DATA_WIDTH-1:0]   r_src_data;
    logic                    r_src_valid;
    logic                    r_src_sop;
    logic                    r_src_eop;
    logic                    r_order_err;
    logic                    w_fwd;
    logic                    w_stray;
    logic [DATA_WIDTH-1:0]   w_data;

    // Only a lane that holds a dispatched frame may feed the output, so stale
    // engine output after a reset never reaches src.
    assign w_fwd    = lane_src_valid[r_out_sel] && lane_busy[r_out_sel];
    assign w_stray  = lane_src_valid[!r_out_sel];
    assign w_data   = r_out_sel ? lane_src_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                : lane_src_data[DATA_WIDTH-1:0];
    assign busy_clr = (w_fwd && lane_src_eop[r_out_sel]) ? (r_out_sel ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_sel   <= 1'b0;
            r_src_data  <= '0;
            r_src_valid <= 1'b0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
            r_order_err <= 1'b0;
        end else begin
            r_src_valid <= w_fwd;
            r_src_sop   <= w_fwd && lane_src_sop[r_out_sel];
            r_src_eop   <= w_fwd && lane_src_eop[r_out_sel];
            if (w_fwd) begin
                r_src_data <= w_data;
            end
            if (busy_clr != 2'b00) begin
                r_out_sel <= !r_out_sel;
            end
            r_order_err <= r_order_err | w_stray;
        end
    end

    assign src_data  = r_src_data;
    assign src_valid = r_src_valid;
    assign src_sop   = r_src_sop;
    assign src_eop   = r_src_eop;
    assign order_err = r_order_err;
endmodule

// File: rtl/sort_lane_dispatch.sv
// rtl/sort_lane_dispatch.sv - round-robin frame dispatch to two sort lanes; SORT_LANE_DISPATCH_STATS_EN adds frame counters
module sort_lane_dispatch
    import sort_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LENGTH = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           snk_data,
    input  logic                            snk_valid,
    input  logic                            snk_sop,
    input  logic                            snk_eop,
    output logic                            snk_ready,
    output logic [DATA_WIDTH-1:0]           lane_snk_data,
    output logic [NUM_LANES-1:0]            lane_snk_valid,
    output logic [NUM_LANES-1:0]            lane_snk_sop,
    output logic [NUM_LANES-1:0]            lane_snk_eop,
    input  logic [NUM_LANES-1:0]            lane_snk_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_src_data,
    input  logic [NUM_LANES-1:0]            lane_src_valid,
    input  logic [NUM_LANES-1:0]            lane_src_sop,
    input  logic [NUM_LANES-1:0]            lane_src_eop,
    output logic [DATA_WIDTH-1:0]           src_data,
    output logic                            src_valid,
    output logic                            src_sop,
    output logic                            src_eop,
    output logic [NUM_LANES-1:0]            lane_busy,
    output logic                            len_err,
    output logic                            order_err
`ifdef SORT_LANE_DISPATCH_STATS_EN
    ,
    output logic [15:0]                     frames_in,
    output logic [15:0]                     frames_out
`endif
);
    localparam int              CW      = $clog2(MAX_LENGTH) + 1;
    localparam logic [CW-1:0]   LEN_MAX = CW'(MAX_LENGTH);

    in_state_t               r_state;
    lane_idx_t               r_in_sel;
    logic [CW-1:0]           r_cnt;
    logic                    r_snk_ready;
    logic [DATA_WIDTH-1:0]   r_lane_data;
    logic [NUM_LANES-1:0]    r_lane_valid;
    logic [NUM_LANES-1:0]    r_lane_sop;
    logic [NUM_LANES-1:0]    r_lane_eop;
    logic [NUM_LANES-1:0]    r_busy;
    logic                    r_len_err;

    logic                    w_take;
    logic                    w_start;
    logic                    w_fwd;
    logic                    w_last;
    logic [CW-1:0]           w_cnt_next;
    logic [NUM_LANES-1:0]    w_sel_mask;
    logic [NUM_LANES-1:0]    w_busy_set;
    logic [NUM_LANES-1:0]    w_busy_clr;
    logic [NUM_LANES-1:0]    w_busy_next;
    logic                    w_ready_same;
    logic                    w_ready_other;

    assign w_take      = snk_valid && r_snk_ready;
    assign w_start     = (r_state == IDLE) && w_take && snk_sop;
    assign w_fwd       = w_start || ((r_state == FILL) && w_take);
    assign w_cnt_next  = (r_state == IDLE) ? CW'(1) : r_cnt + CW'(1);
    assign w_last      = (w_cnt_next == LEN_MAX);
    assign w_sel_mask  = r_in_sel ? 2'b10 : 2'b01;
    assign w_busy_set  = w_start ? w_sel_mask : 2'b00;
    // Clear from the merge side applies before a same-cycle set.
    assign w_busy_next = (r_busy & ~w_busy_clr) | w_busy_set;

    assign w_ready_same  = !w_busy_next[r_in_sel] && lane_snk_ready[r_in_sel];
    assign w_ready_other = !w_busy_next[!r_in_sel] && lane_snk_ready[!r_in_sel];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_in_sel     <= 1'b0;
            r_cnt        <= '0;
            r_snk_ready  <= 1'b0;
            r_lane_data  <= '0;
            r_lane_valid <= '0;
            r_lane_sop   <= '0;
            r_lane_eop   <= '0;
            r_busy       <= '0;
            r_len_err    <= 1'b0;
        end else begin
            r_busy       <= w_busy_next;
            r_lane_valid <= '0;
            r_lane_sop   <= '0;
            r_lane_eop   <= '0;
            if (w_fwd) begin
                r_lane_data  <= snk_data;
                r_lane_valid <= w_sel_mask;
                r_lane_sop   <= (r_state == IDLE) ? w_sel_mask : 2'b00;
                r_lane_eop   <= (snk_eop || w_last) ? w_sel_mask : 2'b00;
                r_cnt        <= w_cnt_next;
                if (snk_eop) begin
                    r_len_err   <= r_len_err | !w_last;
                    r_state     <= CLOSE;
                    r_snk_ready <= 1'b0;
                end else if (w_last) begin
                    // Overlong frame: lane sees a forced eop, the tail is swallowed.
                    r_len_err   <= 1'b1;
                    r_state     <= FLUSH;
                    r_snk_ready <= 1'b1;
                end else begin
                    r_state     <= FILL;
                    r_snk_ready <= 1'b1;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_snk_ready <= w_ready_same;
                    end
                    FILL: begin
                        r_snk_ready <= 1'b1;
                    end
                    FLUSH: begin
                        if (w_take && snk_eop) begin
                            r_state     <= CLOSE;
                            r_snk_ready <= 1'b0;
                        end
                    end
                    CLOSE: begin
                        r_in_sel    <= !r_in_sel;
                        r_state     <= IDLE;
                        r_snk_ready <= w_ready_other;
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_snk_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    sort_lane_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .clock          (clock),
        .reset          (reset),
        .lane_src_data  (lane_src_data),
        .lane_src_valid (lane_src_valid),
        .lane_src_sop   (lane_src_sop),
        .lane_src_eop   (lane_src_eop),
        .lane_busy      (r_busy),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_sop        (src_sop),
        .src_eop        (src_eop),
        .order_err      (order_err),
        .busy_clr       (w_busy_clr)
    );

`ifdef SORT_LANE_DISPATCH_STATS_EN
    logic [15:0] r_frames_in;
    logic [15:0] r_frames_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frames_in  <= '0;
            r_frames_out <= '0;
        end else begin
            if (r_state == CLOSE) begin
                r_frames_in <= r_frames_in + 16'd1;
            end
            if (src_valid && src_eop) begin
                r_frames_out <= r_frames_out + 16'd1;
            end
        end
    end

    assign frames_in  = r_frames_in;
    assign frames_out = r_frames_out;
`endif

    assign snk_ready      = r_snk_ready;
    assign lane_snk_data  = r_lane_data;
    assign lane_snk_valid = r_lane_valid;
    assign lane_snk_sop   = r_lane_sop;
    assign lane_snk_eop   = r_lane_eop;
    assign lane_busy      = r_busy;
    assign len_err        = r_len_err;
endmodule
